// File: rtl/gps_navi_bit_scheduler.sv
// rtl/gps_navi_bit_scheduler.sv - GPS navigation bit scheduler: word buffering, bit shifting, NCO gating
module gps_navi_bit_scheduler #(
    parameter int BITS_PER_WORD       = 30,
    parameter int WORDS_PER_SUBFRAME  = 10,
    parameter int SUBFRAMES_PER_FRAME = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     chip_tick,
    input  logic [BITS_PER_WORD-1:0] word_data,
    input  logic                     word_valid,
    output logic                     word_ready,
    output logic                     nco_send_en,
    output logic                     nco_enable,
    input  logic                     navi_tick,
    output logic                     nav_bit,
    output logic                     bit_strobe,
    output logic [3:0]               word_cnt,
    output logic [2:0]               subframe_cnt,
    output logic                     frame_start,
    output logic                     busy,
    output logic                     underrun
);

    localparam int BIT_W = $clog2(BITS_PER_WORD);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_DATA = 2'd1,
        S_RUN       = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic                     alive_q;
    logic [BITS_PER_WORD-1:0] hold_q, hold_d;
    logic                     hold_full_q, hold_full_d;
    logic [BITS_PER_WORD-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]         bit_idx_q, bit_idx_d;
    logic [3:0]               word_cnt_q, word_cnt_d;
    logic [2:0]               subframe_cnt_q, subframe_cnt_d;
    logic                     underrun_q, underrun_d;
    logic                     bit_strobe_q, bit_strobe_d;
    logic                     frame_start_q, frame_start_d;
    logic                     tick_prev_q;

    logic handshake;
    logic tick_ev;
    logic load_first;

    // word_ready stays low until the first clock after reset release
    assign word_ready = alive_q && !hold_full_q;
    assign handshake  = word_valid && word_ready;
    assign tick_ev    = navi_tick && !tick_prev_q;
    assign load_first = !stop && hold_full_q &&
                        ((state_q == S_IDLE && start) || state_q == S_WAIT_DATA);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:      if (start) state_d = hold_full_q ? S_RUN : S_WAIT_DATA;
                S_WAIT_DATA: if (hold_full_q) state_d = S_RUN;
                S_RUN:       state_d = S_RUN;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        nco_send_en = (state_q == S_RUN);
        busy        = (state_q != S_IDLE);
    end

    always_comb begin
        hold_d         = hold_q;
        hold_full_d    = hold_full_q;
        shift_d        = shift_q;
        bit_idx_d      = bit_idx_q;
        word_cnt_d     = word_cnt_q;
        subframe_cnt_d = subframe_cnt_q;
        underrun_d     = underrun_q;
        bit_strobe_d   = 1'b0;
        frame_start_d  = 1'b0;

        if (stop) begin
            hold_full_d    = 1'b0;
            shift_d        = '0;
            bit_idx_d      = '0;
            word_cnt_d     = '0;
            subframe_cnt_d = '0;
        end else begin
            if (handshake) begin
                hold_d      = word_data;
                hold_full_d = 1'b1;
            end
            if (state_q == S_IDLE && start) begin
                underrun_d = 1'b0;
            end
            if (load_first) begin
                shift_d        = hold_q;
                hold_full_d    = 1'b0;
                bit_idx_d      = '0;
                word_cnt_d     = '0;
                subframe_cnt_d = '0;
                bit_strobe_d   = 1'b1;
                frame_start_d  = 1'b1;
            end else if (state_q == S_RUN && tick_ev) begin
                bit_strobe_d = 1'b1;
                if (bit_idx_q != BIT_W'(BITS_PER_WORD - 1)) begin
                    shift_d   = {shift_q[BITS_PER_WORD-2:0], 1'b0};
                    bit_idx_d = bit_idx_q + 1'b1;
                end else begin
                    bit_idx_d = '0;
                    if (word_cnt_q == 4'(WORDS_PER_SUBFRAME - 1)) begin
                        word_cnt_d = '0;
                        if (subframe_cnt_q == 3'(SUBFRAMES_PER_FRAME - 1)) begin
                            subframe_cnt_d = '0;
                            frame_start_d  = 1'b1;
                        end else begin
                            subframe_cnt_d = subframe_cnt_q + 1'b1;
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                    // An empty holding register sends a zero word; the next boundary retries
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else begin
                        shift_d    = '0;
                        underrun_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alive_q        <= 1'b0;
            hold_q         <= '0;
            hold_full_q    <= 1'b0;
            shift_q        <= '0;
            bit_idx_q      <= '0;
            word_cnt_q     <= '0;
            subframe_cnt_q <= '0;
            underrun_q     <= 1'b0;
            bit_strobe_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            tick_prev_q    <= 1'b0;
        end else begin
            alive_q        <= 1'b1;
            hold_q         <= hold_d;
            hold_full_q    <= hold_full_d;
            shift_q        <= shift_d;
            bit_idx_q      <= bit_idx_d;
            word_cnt_q     <= word_cnt_d;
            subframe_cnt_q <= subframe_cnt_d;
            underrun_q     <= underrun_d;
            bit_strobe_q   <= bit_strobe_d;
            frame_start_q  <= frame_start_d;
            tick_prev_q    <= navi_tick;
        end
    end

    assign nco_enable   = chip_tick && nco_send_en;
    assign nav_bit      = shift_q[BITS_PER_WORD-1];
    assign bit_strobe   = bit_strobe_q;
    assign frame_start  = frame_start_q;
    assign word_cnt     = word_cnt_q;
    assign subframe_cnt = subframe_cnt_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_gps_navi_bit_scheduler.sv
// tb/tb_gps_navi_bit_scheduler.sv - directed/randomized bench with a bit-stream reference model
module tb_gps_navi_bit_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        chip_tick = 1'b0;
    logic [29:0] word_data = '0;
    logic        word_valid = 1'b0;
    logic        navi_tick = 1'b0;
    logic        word_ready, nco_send_en, nco_enable, nav_bit, bit_strobe;
    logic        frame_start, busy, underrun;
    logic [3:0]  word_cnt;
    logic [2:0]  subframe_cnt;

    gps_navi_bit_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .chip_tick   (chip_tick),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .nco_send_en (nco_send_en),
        .nco_enable  (nco_enable),
        .navi_tick   (navi_tick),
        .nav_bit     (nav_bit),
        .bit_strobe  (bit_strobe),
        .word_cnt    (word_cnt),
        .subframe_cnt(subframe_cnt),
        .frame_start (frame_start),
        .busy        (busy),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: position in the transmitted bit stream plus the buffered word
    logic [29:0] m_hold, m_cur;
    bit          m_full, m_run, m_busy, m_under;
    int          m_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_hold = '0; m_cur = '0; m_full = 0; m_run = 0; m_busy = 0; m_under = 0; m_n = 0;
    endtask

    task automatic m_stop();
        m_cur = '0; m_full = 0; m_run = 0; m_busy = 0; m_n = 0;
    endtask

    task automatic m_load();
        m_cur = m_hold; m_full = 0; m_n = 0; m_run = 1; m_busy = 1;
    endtask

    task automatic m_tick();
        m_n++;
        if (m_n % 30 == 0) begin
            if (m_full) begin
                m_cur  = m_hold;
                m_full = 0;
            end else begin
                m_cur   = '0;
                m_under = 1;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        chip_tick = 1'($urandom_range(0, 1));
        #1;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".nav_bit"},      nav_bit,      m_cur[29 - (m_n % 30)]);
        chk({tag, ".word_cnt"},     word_cnt,     (m_n / 30) % 10);
        chk({tag, ".subframe_cnt"}, subframe_cnt, (m_n / 300) % 5);
        chk({tag, ".underrun"},     underrun,     m_under);
        chk({tag, ".busy"},         busy,         m_busy);
        chk({tag, ".nco_send_en"},  nco_send_en,  m_run);
        chk({tag, ".nco_enable"},   nco_enable,   chip_tick & m_run);
        chk({tag, ".word_ready"},   word_ready,   !m_full);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".outputs"},
            {word_ready, nco_send_en, nco_enable, nav_bit, bit_strobe, word_cnt,
             subframe_cnt, frame_start, busy, underrun}, 0);
    endtask

    task automatic tick(input string tag);
        navi_tick = 1'b1;
        cyc();
        navi_tick = 1'b0;
        if (m_run) begin
            m_tick();
            chk({tag, ".strobe"}, bit_strobe, 1);
            chk({tag, ".frame_start"}, frame_start, (m_n % 1500) == 0);
        end else begin
            chk({tag, ".no_strobe"}, bit_strobe, 0);
        end
        check_outs(tag);
        cyc();
        chk({tag, ".strobe_low"}, bit_strobe, 0);
    endtask

    task automatic offer(input logic [29:0] w);
        chk("offer.ready", word_ready, 1);
        word_valid = 1'b1;
        word_data  = w;
        cyc();
        word_valid = 1'b0;
        m_hold = w;
        m_full = 1;
        check_outs("offer");
    endtask

    task automatic feed_until(input int target, input string tag);
        while (m_n < target) begin
            if (!m_full) offer(30'($urandom));
            tick(tag);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");
        rst = 1'b1;
        #1;
        chk("reset.ready_release", word_ready, 0);
        cyc();
        check_outs("post_reset");

        // First word presented together with start: goes through WAIT_DATA
        word_data  = 30'h2AAAAAAA;
        word_valid = 1'b1;
        start      = 1'b1;
        cyc();
        word_valid = 1'b0;
        start      = 1'b0;
        m_hold = 30'h2AAAAAAA; m_full = 1; m_busy = 1;
        chk("t1.strobe_early", bit_strobe, 0);
        check_outs("t1.c1");
        cyc();
        m_load();
        chk("t1.strobe", bit_strobe, 1);
        chk("t1.frame_start", frame_start, 1);
        chk("t1.nav_bit", nav_bit, 1);
        check_outs("t1.c2");
        cyc();
        chk("t1.strobe_once", bit_strobe, 0);
        repeat (5) tick("t1.alt");

        // Level held high counts as a single tick event
        navi_tick = 1'b1;
        cyc();
        m_tick();
        chk("hold.strobe", bit_strobe, 1);
        check_outs("hold");
        repeat (4) begin
            cyc();
            chk("hold.no_repeat", bit_strobe, 0);
        end
        navi_tick = 1'b0;
        cyc();
        chk("hold.low", bit_strobe, 0);
        check_outs("hold.end");

        // Continuous feed across subframe and frame boundaries
        feed_until(60 * 30, "feed");
        chk("feed.underrun", underrun, 0);
        chk("feed.word_cnt", word_cnt, 0);

        stop = 1'b1;
        cyc();
        stop = 1'b0;
        m_stop();
        check_outs("stop1");

        // Start directly from IDLE with a full holding register, then starve it
        offer(30'h3F00FF0F);
        start = 1'b1;
        cyc();
        start = 1'b0;
        m_load();
        m_under = 0;
        chk("t3.strobe", bit_strobe, 1);
        chk("t3.frame_start", frame_start, 1);
        check_outs("t3.load");
        repeat (30) tick("t3.starve");
        chk("t3.underrun", underrun, 1);
        chk("t3.nav_zero", nav_bit, 0);
        repeat (10) tick("t3.zero");
        offer(30'($urandom) | 30'h20000000);
        feed_until(60, "t3.resume");
        chk("t3.resume_wc", word_cnt, 2);
        feed_until(3 * 30 + 12, "t3.to_stop");
        if (!m_full) offer(30'($urandom));

        // Stop with a concurrent tick edge and offered word
        stop       = 1'b1;
        navi_tick  = 1'b1;
        word_valid = 1'b1;
        word_data  = 30'($urandom);
        cyc();
        stop       = 1'b0;
        navi_tick  = 1'b0;
        word_valid = 1'b0;
        m_stop();
        chk("stop.no_strobe", bit_strobe, 0);
        check_outs("stop");
        cyc();
        chk("stop.no_strobe2", bit_strobe, 0);
        check_outs("stop.after");

        // Start with nothing buffered: WAIT_DATA ignores ticks
        start = 1'b1;
        cyc();
        start = 1'b0;
        m_busy  = 1;
        m_under = 0;
        check_outs("wait");
        repeat (3) tick("wait.tick");
        cyc();
        check_outs("wait.idle");
        offer(30'($urandom));
        chk("wait.strobe_early", bit_strobe, 0);
        cyc();
        m_load();
        chk("wait.strobe", bit_strobe, 1);
        chk("wait.frame_start", frame_start, 1);
        check_outs("wait.load");
        repeat (5) tick("wait.run");
        feed_until(40, "wait.run2");

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b0;
        #1;
        check_zero("async_reset");
        m_reset();
        @(negedge clk);
        rst = 1'b1;
        cyc();
        check_outs("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
